// File: rtl/fc_mac_array_if.sv
// fc_mac_array_if: the handshake and data bundle of the fully-connected output stage.
//   start/bias          : inference launch with per-column bias (channel c at [c*B_W +: B_W])
//   in_valid/in_ready   : input beat handshake; in_data is shared, weight is per column
//   out_valid/out_ready : result handshake; out_data holds channel c at [c*OUT_W +: OUT_W]
//   busy                : block is not idle
// master = the upstream/downstream driver, slave = the MAC array.
interface fc_mac_array_if #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 11,
  parameter int W_W    = 8,
  parameter int B_W    = 8,
  parameter int OUT_W  = 16
);
  logic                       start;
  logic [NUM_CH*B_W-1:0]      bias;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_W-1:0]     in_data;
  logic [NUM_CH*W_W-1:0]      weight;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_CH*OUT_W-1:0]    out_data;
  logic                       busy;

  modport master (
    output start, bias, in_valid, in_data, weight, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, bias, in_valid, in_data, weight, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fc_mac_array.sv
// fc_mac_array: NUM_CH neuron columns sharing one serial input stream. Each column
// multiplies every beat by its own weight, accumulates IN_LEN products, adds a
// Q-aligned bias, then rounds half-to-even, optionally applies ReLU and saturates.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fc_mac_array_if.slave (start/bias, input beat handshake, result handshake, busy)
module fc_mac_array #(
  parameter int NUM_CH = 4,
  parameter int IN_LEN = 256,
  parameter int IN_W   = 11,
  parameter int W_W    = 8,
  parameter int B_W    = 8,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int RELU   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  fc_mac_array_if.slave bus
);

  localparam int PROD_W = IN_W + W_W;
  localparam int CNT_W  = $clog2(IN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_LEN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC, S_DRAIN, S_BIAS, S_ROUND, S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]          cnt;
  logic                      vld_p1;
  logic signed [PROD_W-1:0]  prod_p1 [NUM_CH];
  logic signed [ACC_W-1:0]   acc_p2  [NUM_CH];
  logic signed [B_W-1:0]     bias_q  [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]   out_data_q;
  logic                      in_ready_w;
  logic                      beat;

  function automatic logic signed [PROD_W-1:0] mul(input logic signed [IN_W-1:0] x,
                                                   input logic signed [W_W-1:0]  w);
    logic signed [PROD_W-1:0] xe, we;
    xe = {{W_W{x[IN_W-1]}}, x};
    we = {{IN_W{w[W_W-1]}}, w};
    return xe * we;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic signed [ACC_W-1:0] align_bias(input logic signed [B_W-1:0] b);
    logic signed [ACC_W-1:0] t;
    t = {{(ACC_W-B_W){b[B_W-1]}}, b};
    return t <<< FRAC;
  endfunction

  // Round half to even: bump when the dropped part exceeds one half, or equals
  // one half and the kept part is odd.
  function automatic logic signed [ACC_W-1:0] round_rne(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] q;
    logic [FRAC-1:0]         r;
    logic                    up;
    q  = a >>> FRAC;
    r  = a[FRAC-1:0];
    up = r[FRAC-1] & ((|r[FRAC-2:0]) | q[0]);
    return q + ACC_W'(up);
  endfunction

  function automatic logic signed [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] q);
    logic signed [ACC_W-1:0] v;
    v = q;
    if ((RELU != 0) && (v < 0)) v = '0;
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    return v[OUT_W-1:0];
  endfunction

  assign in_ready_w    = (state == S_ACC);
  assign beat          = bus.in_valid & in_ready_w;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state == S_OUT);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ACC;
      S_ACC:   if (beat && (cnt == CNT_LAST)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_BIAS;
      S_BIAS:  state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      vld_p1     <= 1'b0;
      out_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        prod_p1[c] <= '0;
        acc_p2[c]  <= '0;
        bias_q[c]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            vld_p1 <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              prod_p1[c] <= '0;
              acc_p2[c]  <= '0;
              bias_q[c]  <= bus.bias[c*B_W +: B_W];
            end
          end
        end
        S_ACC: begin
          // p1: product register, one per column
          vld_p1 <= beat;
          if (beat) begin
            cnt <= cnt + CNT_W'(1);
            for (int c = 0; c < NUM_CH; c++)
              prod_p1[c] <= mul(bus.in_data, bus.weight[c*W_W +: W_W]);
          end
          // p2: accumulate the previous beat's product
          if (vld_p1) begin
            for (int c = 0; c < NUM_CH; c++)
              acc_p2[c] <= acc_p2[c] + sext_prod(prod_p1[c]);
          end
        end
        S_DRAIN: begin
          // p2: last product still in flight
          vld_p1 <= 1'b0;
          if (vld_p1) begin
            for (int c = 0; c < NUM_CH; c++)
              acc_p2[c] <= acc_p2[c] + sext_prod(prod_p1[c]);
          end
        end
        S_BIAS: begin
          for (int c = 0; c < NUM_CH; c++)
            acc_p2[c] <= acc_p2[c] + align_bias(bias_q[c]);
        end
        S_ROUND: begin
          // output register: round, ReLU, saturate
          for (int c = 0; c < NUM_CH; c++)
            out_data_q[c*OUT_W +: OUT_W] <= relu_sat(round_rne(acc_p2[c]));
        end
        default: ;
      endcase
    end
  end

endmodule
